// File: rtl/cu_param_pkg.sv
// Shared types and constants for the parametrised multi-cycle control unit.
// Holds the FSM state enum, instruction class codes, bus mux source codes
// and the ALU operation codes that the control unit drives.
package cu_param_pkg;

  typedef enum logic [3:0] {
    StFetch1,
    StFetch2,
    StExec,
    StAlu2,
    StBr,
    StOpnd,
    StMrd,
    StMwr,
    StPush2,
    StHalt,
    StInt1,
    StInt2,
    StInt3,
    StInt4
  } cu_state_e;

  // Instruction class, taken from the top four opcode bits.
  localparam logic [3:0] OP_ALU0 = 4'h0;
  localparam logic [3:0] OP_ALU1 = 4'h1;
  localparam logic [3:0] OP_ALU2 = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_LDD  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_STI  = 4'h9;
  localparam logic [3:0] OP_LDR  = 4'hA;
  localparam logic [3:0] OP_RSVD = 4'hB;  // NOP, or RETI when INTR_EN is defined
  localparam logic [3:0] OP_PUSH = 4'hC;
  localparam logic [3:0] OP_POP  = 4'hD;
  localparam logic [3:0] OP_LDSP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Bus-1 sources.
  localparam logic [2:0] M1_GPRF = 3'd0;
  localparam logic [2:0] M1_PC   = 3'd5;
  localparam logic [2:0] M1_SP   = 3'd6;

  // Bus-2 sources.
  localparam logic [1:0] M2_ALU  = 2'd0;
  localparam logic [1:0] M2_BUS1 = 2'd1;
  localparam logic [1:0] M2_MEM  = 2'd2;
  localparam logic [1:0] M2_VEC  = 2'd3;

  // ALU operations driven from ALU2.
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;

endpackage

// File: rtl/cu_onehot_dec.sv
// Binary-to-one-hot decoder with enable, used for the GPRF write enables.
// Ports:
//   en_i      - decoder enable; all outputs low when clear
//   sel_i     - binary register index
//   onehot_o  - one-hot write enable, bit sel_i set when enabled
module cu_onehot_dec #(
  parameter int unsigned SelW = 2
) (
  input  logic                   en_i,
  input  logic [SelW-1:0]        sel_i,
  output logic [(2**SelW)-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/cu_param_mc.sv
// Parametrised multi-cycle control unit for an accumulator/register machine with
// 2**REG_W general purpose registers. Moore FSM decoding the IR into datapath
// strobes, bus mux selects, GPRF selects and memory requests. Memory states hold
// their request until mem_ready and fire their strobes only in the ready cycle.
//
// Optional feature: define INTR_EN to add irq/irq_ack, the interrupt entry
// sequence (INT1..INT4), RETI on class B and wake-from-HALT on irq.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   opcode            - IR contents: class | rs | rd
//   alu_flags         - ALU status; bit FLAG_IDX is the branch condition
//   mem_ready         - memory completes the current access this cycle
//   irq / irq_ack     - interrupt request / acknowledge (INTR_EN only)
//   load_R            - one-hot GPRF write enable
//   gprf_sel_read/write - GPRF port selects
//   inc_PC .. load_SP - datapath strobes
//   alu_select        - ALU operation
//   Mux_1_sel, Mux_2_sel - bus source selects
//   read, write       - memory request
//   halted            - unit is in HALT
module cu_param_mc
  import cu_param_pkg::*;
#(
  parameter int unsigned REG_W    = 2,
  parameter int unsigned OPC_W    = 4 + 2 * REG_W,
  parameter int unsigned FLAG_IDX = 0,
  parameter logic [7:0]  IRQ_VEC  = 8'hF0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPC_W-1:0]      opcode,
  input  logic [7:0]            alu_flags,
  input  logic                  mem_ready,
`ifdef INTR_EN
  input  logic                  irq,
  output logic                  irq_ack,
`endif
  output logic [(2**REG_W)-1:0] load_R,
  output logic [REG_W-1:0]      gprf_sel_read,
  output logic [REG_W-1:0]      gprf_sel_write,
  output logic                  inc_PC,
  output logic                  load_PC,
  output logic                  load_Add_R,
  output logic                  load_Reg_Y,
  output logic                  load_Reg_Z,
  output logic                  load_IR,
  output logic                  inc_SP,
  output logic                  dec_SP,
  output logic                  load_SP,
  output logic [3:0]            alu_select,
  output logic [2:0]            Mux_1_sel,
  output logic [1:0]            Mux_2_sel,
  output logic                  read,
  output logic                  write,
  output logic                  halted
);

  // The vector itself is supplied by the datapath on bus-2 source 3.
  localparam logic [7:0] UnusedIrqVec = IRQ_VEC;

  cu_state_e        state_q, state_d;
  logic [REG_W-1:0] rs_q, rs_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [3:0]       cls_q, cls_d;
  logic             load_r_en;
  logic             take_irq;
  logic             is_reti;

  logic [3:0]       opc_cls;
  logic [REG_W-1:0] opc_rs;
  logic [REG_W-1:0] opc_rd;

  assign opc_cls = opcode[OPC_W-1 -: 4];
  assign opc_rs  = opcode[2*REG_W-1 -: REG_W];
  assign opc_rd  = opcode[REG_W-1:0];

`ifdef INTR_EN
  logic ie_q, ie_d;

  assign take_irq = irq && ie_q;
  assign is_reti  = (cls_q == OP_RSVD);

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= 1'b1;
    end else begin
      ie_q <= ie_d;
    end
  end
`else
  assign take_irq = 1'b0;
  assign is_reti  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch1;
      rs_q    <= '0;
      rd_q    <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rs_d           = rs_q;
    rd_d           = rd_q;
    cls_d          = cls_q;
`ifdef INTR_EN
    ie_d           = ie_q;
    irq_ack        = 1'b0;
`endif
    load_r_en      = 1'b0;
    gprf_sel_read  = '0;
    gprf_sel_write = '0;
    inc_PC         = 1'b0;
    load_PC        = 1'b0;
    load_Add_R     = 1'b0;
    load_Reg_Y     = 1'b0;
    load_Reg_Z     = 1'b0;
    load_IR        = 1'b0;
    inc_SP         = 1'b0;
    dec_SP         = 1'b0;
    load_SP        = 1'b0;
    alu_select     = '0;
    Mux_1_sel      = M1_GPRF;
    Mux_2_sel      = M2_ALU;
    read           = 1'b0;
    write          = 1'b0;
    halted         = 1'b0;

    // While reset is held every output stays low; the flops reload on the edge.
    if (!rst) begin
      unique case (state_q)
        StFetch1: begin
          if (take_irq) begin
            state_d = StInt1;
          end else begin
            Mux_1_sel  = M1_PC;
            Mux_2_sel  = M2_BUS1;
            load_Add_R = 1'b1;
            state_d    = StFetch2;
          end
        end

        StFetch2: begin
          read      = 1'b1;
          Mux_2_sel = M2_MEM;
          if (mem_ready) begin
            load_IR = 1'b1;
            inc_PC  = 1'b1;
            state_d = StExec;
          end
        end

        StExec: begin
          cls_d   = opc_cls;
          rs_d    = opc_rs;
          rd_d    = opc_rd;
          state_d = StFetch1;
          unique case (opc_cls)
            OP_ALU0, OP_ALU1, OP_ALU2: begin
              alu_select = opc_cls;
              load_Reg_Z = 1'b1;
            end
            OP_AND, OP_NOT: begin
              gprf_sel_read = opc_rs;
              Mux_1_sel     = M1_GPRF;
              Mux_2_sel     = M2_BUS1;
              load_Reg_Y    = 1'b1;
              state_d       = StAlu2;
            end
            OP_JMP, OP_JC: begin
              if (opc_cls == OP_JMP || alu_flags[FLAG_IDX]) begin
                Mux_1_sel  = M1_PC;
                Mux_2_sel  = M2_BUS1;
                load_Add_R = 1'b1;
                state_d    = StBr;
              end else begin
                // Not taken: step over the branch target operand.
                inc_PC = 1'b1;
              end
            end
            OP_LDD, OP_LDI, OP_STI: begin
              Mux_1_sel  = M1_PC;
              Mux_2_sel  = M2_BUS1;
              load_Add_R = 1'b1;
              state_d    = StOpnd;
            end
            OP_LDR: begin
              gprf_sel_read = opc_rs;
              Mux_1_sel     = M1_GPRF;
              Mux_2_sel     = M2_BUS1;
              load_Add_R    = 1'b1;
              state_d       = StMrd;
            end
            OP_PUSH: begin
              dec_SP  = 1'b1;
              state_d = StPush2;
            end
            OP_POP: begin
              Mux_1_sel  = M1_SP;
              Mux_2_sel  = M2_BUS1;
              load_Add_R = 1'b1;
              state_d    = StMrd;
            end
            OP_LDSP: begin
              gprf_sel_read = opc_rs;
              Mux_1_sel     = M1_GPRF;
              load_SP       = 1'b1;
            end
            OP_HALT: begin
              state_d = StHalt;
            end
            default: begin
`ifdef INTR_EN
              // RETI: address the stack top, the pop lands in PC from MRD.
              Mux_1_sel  = M1_SP;
              Mux_2_sel  = M2_BUS1;
              load_Add_R = 1'b1;
              state_d    = StMrd;
`endif
            end
          endcase
        end

        StAlu2: begin
          gprf_sel_read  = rd_q;
          gprf_sel_write = rd_q;
          Mux_2_sel      = M2_ALU;
          alu_select     = (cls_q == OP_AND) ? ALU_AND : ALU_NOT;
          load_r_en      = 1'b1;
          state_d        = StFetch1;
        end

        StBr: begin
          read      = 1'b1;
          Mux_2_sel = M2_MEM;
          if (mem_ready) begin
            load_PC = 1'b1;
            state_d = StFetch1;
          end
        end

        StOpnd: begin
          read      = 1'b1;
          Mux_2_sel = M2_MEM;
          if (mem_ready) begin
            inc_PC = 1'b1;
            if (cls_q == OP_LDD) begin
              load_r_en = 1'b1;
              state_d   = StFetch1;
            end else begin
              load_Add_R = 1'b1;
              state_d    = (cls_q == OP_STI) ? StMwr : StMrd;
            end
          end
        end

        StMrd: begin
          read      = 1'b1;
          Mux_2_sel = M2_MEM;
          if (!is_reti) begin
            gprf_sel_write = rd_q;
          end
          if (mem_ready) begin
            state_d = StFetch1;
            if (is_reti) begin
              load_PC = 1'b1;
              inc_SP  = 1'b1;
`ifdef INTR_EN
              ie_d    = 1'b1;
`endif
            end else begin
              load_r_en = 1'b1;
              inc_SP    = (cls_q == OP_POP);
            end
          end
        end

        StPush2: begin
          Mux_1_sel  = M1_SP;
          Mux_2_sel  = M2_BUS1;
          load_Add_R = 1'b1;
          state_d    = StMwr;
        end

        StMwr: begin
          write         = 1'b1;
          gprf_sel_read = rs_q;
          Mux_1_sel     = M1_GPRF;
          if (mem_ready) begin
            state_d = StFetch1;
          end
        end

        StHalt: begin
          halted = 1'b1;
`ifdef INTR_EN
          if (irq) begin
            state_d = StInt1;
          end
`endif
        end

`ifdef INTR_EN
        StInt1: begin
          dec_SP  = 1'b1;
          state_d = StInt2;
        end

        StInt2: begin
          Mux_1_sel  = M1_SP;
          Mux_2_sel  = M2_BUS1;
          load_Add_R = 1'b1;
          state_d    = StInt3;
        end

        StInt3: begin
          write     = 1'b1;
          Mux_1_sel = M1_PC;
          if (mem_ready) begin
            state_d = StInt4;
          end
        end

        StInt4: begin
          Mux_2_sel = M2_VEC;
          load_PC   = 1'b1;
          irq_ack   = 1'b1;
          ie_d      = 1'b0;
          state_d   = StFetch1;
        end
`endif

        default: begin
          state_d = StFetch1;
        end
      endcase
    end
  end

  cu_onehot_dec #(
    .SelW(REG_W)
  ) u_load_dec (
    .en_i     (load_r_en),
    .sel_i    (rd_q),
    .onehot_o (load_R)
  );

endmodule

// File: tb/tb_cu_param_mc.sv
// Self-checking bench for cu_param_mc (default parameters, REG_W = 2).
// Each instruction is expanded into its expected per-state output vectors;
// memory steps are stretched by random wait cycles in which strobes stay low.
module tb_cu_param_mc;

  typedef struct packed {
    logic [3:0] load_r;
    logic [1:0] sel_rd;
    logic [1:0] sel_wr;
    logic       inc_pc;
    logic       load_pc;
    logic       load_ar;
    logic       load_y;
    logic       load_z;
    logic       load_ir;
    logic       inc_sp;
    logic       dec_sp;
    logic       load_sp;
    logic [3:0] alu;
    logic [2:0] m1;
    logic [1:0] m2;
    logic       mrd;
    logic       mwr;
    logic       halted;
  } out_t;

  typedef struct {
    bit   mem;
    out_t o;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] opcode;
  logic [7:0] alu_flags;
  logic       mem_ready;
`ifdef INTR_EN
  logic       irq;
  logic       irq_ack;
`endif
  logic [3:0] load_R;
  logic [1:0] gprf_sel_read, gprf_sel_write;
  logic       inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR;
  logic       inc_SP, dec_SP, load_SP;
  logic [3:0] alu_select;
  logic [2:0] Mux_1_sel;
  logic [1:0] Mux_2_sel;
  logic       read, write, halted;

  always #5 clk = ~clk;

  cu_param_mc #(
    .REG_W(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .alu_flags      (alu_flags),
    .mem_ready      (mem_ready),
`ifdef INTR_EN
    .irq            (irq),
    .irq_ack        (irq_ack),
`endif
    .load_R         (load_R),
    .gprf_sel_read  (gprf_sel_read),
    .gprf_sel_write (gprf_sel_write),
    .inc_PC         (inc_PC),
    .load_PC        (load_PC),
    .load_Add_R     (load_Add_R),
    .load_Reg_Y     (load_Reg_Y),
    .load_Reg_Z     (load_Reg_Z),
    .load_IR        (load_IR),
    .inc_SP         (inc_SP),
    .dec_SP         (dec_SP),
    .load_SP        (load_SP),
    .alu_select     (alu_select),
    .Mux_1_sel      (Mux_1_sel),
    .Mux_2_sel      (Mux_2_sel),
    .read           (read),
    .write          (write),
    .halted         (halted)
  );

  int    n_checks = 0;
  int    n_fails  = 0;
  step_t steps[$];
  out_t  obs[8];
  int    rd_cnt[8];
  int    inc_cnt[8];
  int    ldr_cnt[8];

  function automatic out_t dut_out();
    out_t o;
    o.load_r  = load_R;
    o.sel_rd  = gprf_sel_read;
    o.sel_wr  = gprf_sel_write;
    o.inc_pc  = inc_PC;
    o.load_pc = load_PC;
    o.load_ar = load_Add_R;
    o.load_y  = load_Reg_Y;
    o.load_z  = load_Reg_Z;
    o.load_ir = load_IR;
    o.inc_sp  = inc_SP;
    o.dec_sp  = dec_SP;
    o.load_sp = load_SP;
    o.alu     = alu_select;
    o.m1      = Mux_1_sel;
    o.m2      = Mux_2_sel;
    o.mrd     = read;
    o.mwr     = write;
    o.halted  = halted;
    return o;
  endfunction

  // A memory access that is still waiting shows its request and selects only.
  function automatic out_t waiting(input out_t o);
    out_t w;
    w         = o;
    w.load_r  = '0;
    w.inc_pc  = 1'b0;
    w.load_pc = 1'b0;
    w.load_ar = 1'b0;
    w.load_y  = 1'b0;
    w.load_z  = 1'b0;
    w.load_ir = 1'b0;
    w.inc_sp  = 1'b0;
    w.dec_sp  = 1'b0;
    w.load_sp = 1'b0;
    return w;
  endfunction

  function automatic void add(input bit mem, input out_t o);
    step_t s;
    s.mem = mem;
    s.o   = o;
    steps.push_back(s);
  endfunction

  function automatic void add_mrd(input logic [1:0] rd, input bit pop);
    out_t o;
    o        = '0;
    o.mrd    = 1'b1;
    o.m2     = 2'd2;
    o.load_r = 4'b0001 << rd;
    o.sel_wr = rd;
    o.inc_sp = pop;
    add(1'b1, o);
  endfunction

  function automatic void add_mwr(input logic [1:0] rs);
    out_t o;
    o        = '0;
    o.mwr    = 1'b1;
    o.sel_rd = rs;
    add(1'b1, o);
  endfunction

  // Expected output sequence of one instruction, from FETCH1 to its last state.
  function automatic void build(input logic [7:0] opc, input logic [7:0] flags);
    out_t       o;
    logic [3:0] cls;
    logic [1:0] rs, rd;
    cls = opc[7:4];
    rs  = opc[3:2];
    rd  = opc[1:0];
    steps.delete();
    o = '0; o.m1 = 3'd5; o.m2 = 2'd1; o.load_ar = 1'b1;
    add(1'b0, o);
    o = '0; o.mrd = 1'b1; o.m2 = 2'd2; o.load_ir = 1'b1; o.inc_pc = 1'b1;
    add(1'b1, o);
    o = '0;
    if (cls <= 4'd2) begin
      o.alu = cls; o.load_z = 1'b1;
      add(1'b0, o);
    end else if (cls == 4'd3 || cls == 4'd4) begin
      o.sel_rd = rs; o.m2 = 2'd1; o.load_y = 1'b1;
      add(1'b0, o);
      o = '0; o.sel_rd = rd; o.sel_wr = rd; o.alu = cls; o.load_r = 4'b0001 << rd;
      add(1'b0, o);
    end else if (cls == 4'd5 || (cls == 4'd6 && flags[0])) begin
      o.m1 = 3'd5; o.m2 = 2'd1; o.load_ar = 1'b1;
      add(1'b0, o);
      o = '0; o.mrd = 1'b1; o.m2 = 2'd2; o.load_pc = 1'b1;
      add(1'b1, o);
    end else if (cls == 4'd6) begin
      o.inc_pc = 1'b1;
      add(1'b0, o);
    end else if (cls >= 4'd7 && cls <= 4'd9) begin
      o.m1 = 3'd5; o.m2 = 2'd1; o.load_ar = 1'b1;
      add(1'b0, o);
      o = '0; o.mrd = 1'b1; o.m2 = 2'd2; o.inc_pc = 1'b1;
      if (cls == 4'd7) o.load_r = 4'b0001 << rd;
      else o.load_ar = 1'b1;
      add(1'b1, o);
      if (cls == 4'd8) add_mrd(rd, 1'b0);
      if (cls == 4'd9) add_mwr(rs);
    end else if (cls == 4'hA) begin
      o.sel_rd = rs; o.m2 = 2'd1; o.load_ar = 1'b1;
      add(1'b0, o);
      add_mrd(rd, 1'b0);
    end else if (cls == 4'hC) begin
      o.dec_sp = 1'b1;
      add(1'b0, o);
      o = '0; o.m1 = 3'd6; o.m2 = 2'd1; o.load_ar = 1'b1;
      add(1'b0, o);
      add_mwr(rs);
    end else if (cls == 4'hD) begin
      o.m1 = 3'd6; o.m2 = 2'd1; o.load_ar = 1'b1;
      add(1'b0, o);
      add_mrd(rd, 1'b1);
    end else if (cls == 4'hE) begin
      o.sel_rd = rs; o.load_sp = 1'b1;
      add(1'b0, o);
    end else begin
      add(1'b0, o);  // B (NOP) and F (HALT): EXEC raises nothing
    end
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // fixed_wait < 0 draws random wait counts; abort_step >= 0 stops early so that
  // reset can be applied mid-instruction (memory steps wait twice first).
  task automatic run_instr(input logic [7:0] opc, input logic [7:0] flags,
                           input int fixed_wait, input int abort_step);
    out_t act, exp;
    build(opc, flags);
    for (int i = 0; i < 8; i++) begin
      obs[i] = '0; rd_cnt[i] = 0; inc_cnt[i] = 0; ldr_cnt[i] = 0;
    end
    for (int s = 0; s < steps.size(); s++) begin
      int waits;
      if (fixed_wait >= 0) waits = fixed_wait;
      else waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (!steps[s].mem) waits = 0;
      if (s == abort_step) begin
        if (steps[s].mem) begin
          for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check($sformatf("op%h_s%0d_hold", opc, s), dut_out(), waiting(steps[s].o));
          end
        end
        return;
      end
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        if (s == 0) begin
          opcode    = opc;
          alu_flags = flags;
        end
        mem_ready = steps[s].mem ? (w == waits) : 1'($urandom);
        #1;
        act = dut_out();
        exp = (w == waits) ? steps[s].o : waiting(steps[s].o);
        check($sformatf("op%h_s%0d_w%0d", opc, s, w), act, exp);
        obs[s]      = act;
        rd_cnt[s]  += int'(act.mrd);
        inc_cnt[s] += int'(act.inc_pc);
        ldr_cnt[s] += int'(act.load_r != 4'b0000);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'($urandom);
      #1;
      check("reset_outputs", dut_out(), out_t'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic halt_check(input int cycles);
    out_t exp;
    exp        = '0;
    exp.halted = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode    = 8'($urandom);
      alu_flags = 8'($urandom);
      #1;
      check("halt", dut_out(), exp);
    end
  endtask

  initial begin
    logic [7:0] opc;
    rst       = 1'b1;
    opcode    = 8'h00;
    alu_flags = 8'h00;
    mem_ready = 1'b0;
`ifdef INTR_EN
    irq       = 1'b0;
`endif
    do_reset(2);

    // AND R1,R2: ALU2 writes R2 from ALU op 3, reads R2.
    run_instr(8'h36, 8'h00, 0, -1);
    check_val("and_load_r", int'(obs[3].load_r), 4);
    check_val("and_alu", int'(obs[3].alu), 3);
    check_val("and_sel_rd", int'(obs[3].sel_rd), 2);

    // LD direct R3 with two wait cycles in every memory state.
    run_instr(8'h73, 8'h00, 2, -1);
    check_val("ldd_read_cycles", rd_cnt[3], 3);
    check_val("ldd_inc_pc_pulses", inc_cnt[3], 1);
    check_val("ldd_load_r_pulses", ldr_cnt[3], 1);
    check_val("ldd_load_r", int'(obs[3].load_r), 8);

    // JC not taken then taken.
    run_instr(8'h60, 8'h00, 0, -1);
    check_val("jc_nt_inc_pc", int'(obs[2].inc_pc), 1);
    run_instr(8'h60, 8'h01, 1, -1);
    check_val("jc_t_load_pc", int'(obs[3].load_pc), 1);

    // PUSH R2 then POP R1.
    run_instr(8'hC8, 8'h00, 1, -1);
    check_val("push_dec_sp", int'(obs[2].dec_sp), 1);
    check_val("push_m1", int'(obs[3].m1), 6);
    check_val("push_write", int'(obs[4].mwr), 1);
    check_val("push_sel_rd", int'(obs[4].sel_rd), 2);
    run_instr(8'hD1, 8'h00, 0, -1);
    check_val("pop_load_r", int'(obs[3].load_r), 2);
    check_val("pop_inc_sp", int'(obs[3].inc_sp), 1);

    // Reset held three cycles while MWR waits on memory.
    run_instr(8'hC8, 8'h00, 0, 4);
    do_reset(3);
    run_instr(8'h10, 8'h00, 0, -1);
    check_val("post_reset_write", int'(obs[0].mwr), 0);
    check_val("post_reset_m1", int'(obs[0].m1), 5);

    // HALT holds until reset.
    run_instr(8'hF5, 8'h00, 0, -1);
    halt_check(4);
    do_reset(1);

    // Randomised instruction stream with occasional mid-instruction resets.
    for (int n = 0; n < 300; n++) begin
      opc = 8'($urandom);
`ifdef INTR_EN
      if (opc[7:4] == 4'hB) opc[7:4] = 4'h0;
`endif
      if (opc[7:4] == 4'hF && $urandom_range(0, 3) != 0) opc[7:4] = 4'hE;
      if ($urandom_range(0, 15) == 0) begin
        run_instr(opc, 8'($urandom), -1, $urandom_range(0, 4));
        do_reset($urandom_range(1, 3));
      end else begin
        run_instr(opc, 8'($urandom), -1, -1);
        if (opc[7:4] == 4'hF) begin
          halt_check(2);
          do_reset(1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cu_param_mc.md
Name: cu_param_mc

Overview:
- Parametrised successor to the 8-bit multi-cycle control unit.
- Drives datapath strobes, bus mux selects and GPRF selects for an N-register (N = 2**REG_W) accumulator/register machine.
- Adds four capabilities:
  - memory wait-state handshake
  - stack PUSH/POP/LDSP using the existing SP strobes
  - HALT
  - corrected PC increment after operand fetch
- Sits between the IR/flags register and the datapath (PC, AR, Y, Z, SP, GPRF, memory).

Parameters:
- REG_W, 2, GPRF select width; N = 2**REG_W registers.
- OPC_W, 4+2*REG_W, opcode width: class [OPC_W-1:OPC_W-4], rs [2*REG_W-1:REG_W], rd [REG_W-1:0].
- FLAG_IDX, 0, alu_flags bit tested by conditional branch.
- IRQ_VEC, 8'hF0, interrupt vector (only used with INTR_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  OPC_W  IR contents
- alu_flags  in  8  ALU status flags
- mem_ready  in  1  memory completes the current read/write this cycle
- load_R  out  N  one-hot GPRF write enable
- gprf_sel_read  out  REG_W  GPRF read port select
- gprf_sel_write  out  REG_W  GPRF write port select
- inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR, inc_SP, dec_SP, load_SP  out  1 each  datapath strobes
- alu_select  out  4  ALU operation
- Mux_1_sel  out  3  bus-1 source: 0 = GPRF, 5 = PC, 6 = SP
- Mux_2_sel  out  2  bus-2 source: 0 = ALU, 1 = bus-1, 2 = memory, 3 = vector
- read, write  out  1 each  memory request
- halted  out  1  processor is in HALT

Behaviour:
- State register clocked on clk.
- Outputs are a combinational function of the state plus latched fields (Moore). In non-memory states they may also depend on opcode and alu_flags.
- Every output defaults to 0 in every state; only the strobes listed below are raised.
- rst=1 at an edge → next state FETCH1, latched rs/rd cleared, all outputs 0 while rst=1. This holds from any state, including mid-wait and HALT.
- Memory rule: any state with read or write asserted holds read/write and the mux selects every cycle until mem_ready=1. All load/inc/dec strobes of that state fire only in the mem_ready=1 cycle, and only then does the state advance.
- rs and rd are latched from opcode in EXEC and used by all later states of that instruction.
- FETCH1: Mux_1=5, Mux_2=1, load_Add_R → FETCH2.
- FETCH2 (memory): read, Mux_2=2, load_IR, inc_PC → EXEC.
- EXEC, decoded on class:
  - 0–2: alu_select = class, load_Reg_Z → FETCH1.
  - 3 AND / 4 NOT: gprf_sel_read = rs, Mux_1=0, Mux_2=1, load_Reg_Y → ALU2.
  - 5 JMP: Mux_1=5, Mux_2=1, load_Add_R → BR.
  - 6 JC:
    - alu_flags[FLAG_IDX]=1: as JMP.
    - else: inc_PC → FETCH1.
  - 7 LD direct / 8 LD indirect / 9 ST indirect: PC→AR → OPND.
  - A LD [rs]: rs→AR → MRD.
  - C PUSH: dec_SP → PUSH2.
  - D POP: Mux_1=6, Mux_2=1, load_Add_R → MRD. inc_SP fires in MRD for POP only.
  - E LDSP: gprf_sel_read = rs, Mux_1=0, load_SP → FETCH1.
  - F HALT → HALT.
  - B: reserved, treated as NOP → FETCH1.
- ALU2: gprf_sel_read = rd, Mux_2=0, alu_select 3 (AND) / 4 (NOT), load_R[rd], gprf_sel_write = rd → FETCH1.
- BR (memory): read, Mux_2=2, load_PC → FETCH1.
- OPND (memory): read, Mux_2=2, inc_PC.
  - class 7: also load_R[rd] → FETCH1.
  - class 8/9: also load_Add_R → MRD (8) or MWR (9).
- MRD (memory): read, Mux_2=2, load_R[rd], gprf_sel_write = rd → FETCH1.
- PUSH2: Mux_1=6, Mux_2=1, load_Add_R → MWR.
- MWR (memory): write, gprf_sel_read = rs, Mux_1=0 → FETCH1.
- HALT: halted=1, no strobes, stays in HALT until rst.
- SP wrap-around is the datapath's responsibility; the control unit does not check it.

Optional Feature:
- INTR_EN defined:
  - Adds ports irq (in 1) and irq_ack (out 1), plus an internal interrupt-enable flag ie, set by reset.
  - In FETCH1, irq=1 and ie=1 → INT1 instead of the normal fetch.
  - INT1: dec_SP.
  - INT2: Mux_1=6, Mux_2=1, load_Add_R.
  - INT3 (memory): write, Mux_1=5.
  - INT4: Mux_2=3, load_PC, irq_ack=1, ie cleared → FETCH1.
  - Class B becomes RETI: POP into PC (MRD with load_PC instead of load_R), then ie set.
  - irq also wakes the unit from HALT.
- INTR_EN undefined: no irq/ie/INT states; class B stays NOP.

Decomposition:
- Package cu_param_pkg holds:
  - state enum
  - class constants (OP_JMP, OP_PUSH, ...)
  - Mux_1/Mux_2 source constants
  - ALU op codes
- One sub-module, cu_onehot_dec: REG_W-to-N one-hot decoder gated by an enable, used for load_R.

Test Plan:
- rst held 3 cycles mid-MWR with mem_ready=0 → next cycle FETCH1, write=0, all strobes 0.
- opcode 8'h3_6 (AND R1,R2) with mem_ready=1 → 4 cycles FETCH1…ALU2; in ALU2 load_R=4'b0100, alu_select=3, gprf_sel_read=2.
- LD direct 8'h7_3 with mem_ready low for 2 cycles in OPND → read held 3 cycles; load_R[3] and inc_PC pulse once, in the ready cycle only.
- JC 8'h60 with alu_flags[0]=0 → inc_PC in EXEC, next state FETCH1; with flag=1 → BR, load_PC=1.
- PUSH R2 (8'hC8) then POP R1 (8'hD1) → dec_SP, load_Add_R(Mux_1=6), write with gprf_sel_read=2; then load_Add_R, read, load_R[1], inc_SP.
- INTR_EN: irq=1 at FETCH1 → INT1..INT4 with dec_SP, write Mux_1=5, load_PC Mux_2=3, irq_ack 1 cycle; HALT then irq → resumes at FETCH1 via INT1.
